// File: rtl/ita_activation.sv
// Two-stage N-lane activation unit: identity, ReLU or integer GELU with a
// valid/ready handshake, flush, and per-lane enables captured with each beat.
module ita_activation #(
    parameter int N  = 16,
    parameter int WI = 8,
    parameter int CW = 18,
    parameter int OW = 26
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      mode_i,
    input  logic [CW-1:0]   b_i,
    input  logic [CW-1:0]   c_i,
    input  logic [N-1:0]    lane_en_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [N*WI-1:0] data_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [N*OW-1:0] data_o
);

    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_GELU = 2'd2;

    // First half of i-GELU: clipped |x| offset by b, squared. |x| lives in CW bits,
    // so the most negative input cannot overflow.
    function automatic logic signed [OW-1:0] gelu_sq(input logic signed [WI-1:0] x,
                                                     input logic signed [CW-1:0] b);
        logic signed [CW-1:0] xc, a, nb, q, p;
        logic signed [OW-1:0] pw;
        xc = CW'(x);
        a  = xc[CW-1] ? -xc : xc;
        nb = -b;
        q  = (a < nb) ? a : nb;
        p  = q + b;
        pw = OW'(p);
        return pw * pw;
    endfunction

    function automatic logic signed [OW-1:0] act_y(input logic [1:0] mode,
                                                   input logic en,
                                                   input logic signed [WI-1:0] x,
                                                   input logic sgn,
                                                   input logic signed [OW-1:0] sq,
                                                   input logic signed [CW-1:0] c);
        logic signed [OW-1:0] xw, cw, l, e, s, y;
        xw = OW'(x);
        cw = OW'(c);
        l  = sq + cw;
        e  = sgn ? -l : l;
        s  = e + cw;
        case (mode)
            MODE_GELU: y = xw * s;
            MODE_RELU: y = sgn ? {OW{1'b0}} : xw;
            default:   y = xw;
        endcase
        return en ? y : {OW{1'b0}};
    endfunction

    logic                 en_s, acc_s, ld1_s, ld2_s;
    logic                 v1_q, v1_d, v2_q, v2_d;
    logic [1:0]           mode_q, mode_d;
    logic signed [CW-1:0] c_q, c_d;
    logic [N-1:0]         len_q, len_d;
    logic [N-1:0]         sgn_q, sgn_d;
    logic signed [WI-1:0] x_q  [N];
    logic signed [WI-1:0] x_d  [N];
    logic signed [OW-1:0] sq_q [N];
    logic signed [OW-1:0] sq_d [N];
    logic signed [OW-1:0] y_q  [N];
    logic signed [OW-1:0] y_d  [N];

    // Handshake, valid pipeline and next-state of both datapath stages.
    always_comb begin
        en_s  = ~v2_q | ready_i;
        acc_s = valid_i & en_s;
        ld1_s = acc_s & ~flush_i;
        ld2_s = en_s & v1_q & ~flush_i;
        if (flush_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else if (en_s) begin
            v1_d = valid_i;
            v2_d = v1_q;
        end else begin
            v1_d = v1_q;
            v2_d = v2_q;
        end
        mode_d = ld1_s ? mode_i    : mode_q;
        c_d    = ld1_s ? c_i       : c_q;
        len_d  = ld1_s ? lane_en_i : len_q;
        for (int k = 0; k < N; k++) begin
            x_d[k]   = ld1_s ? data_i[k*WI +: WI] : x_q[k];
            sgn_d[k] = ld1_s ? data_i[k*WI + WI - 1] : sgn_q[k];
            sq_d[k]  = ld1_s ? gelu_sq(data_i[k*WI +: WI], b_i) : sq_q[k];
            y_d[k]   = ld2_s ? act_y(mode_q, len_q[k], x_q[k], sgn_q[k], sq_q[k], c_q) : y_q[k];
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            mode_q <= 2'd0;
            c_q    <= {CW{1'b0}};
            len_q  <= {N{1'b0}};
            sgn_q  <= {N{1'b0}};
            for (int k = 0; k < N; k++) begin
                x_q[k]  <= {WI{1'b0}};
                sq_q[k] <= {OW{1'b0}};
                y_q[k]  <= {OW{1'b0}};
            end
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            mode_q <= mode_d;
            c_q    <= c_d;
            len_q  <= len_d;
            sgn_q  <= sgn_d;
            for (int k = 0; k < N; k++) begin
                x_q[k]  <= x_d[k];
                sq_q[k] <= sq_d[k];
                y_q[k]  <= y_d[k];
            end
        end
    end

    assign ready_o = en_s;
    assign valid_o = v2_q;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign data_o[g*OW +: OW] = y_q[g];
    end

endmodule

// File: doc/ita_activation.md
ITA_ACTIVATION -- requirements
Module: ita_activation

Interface
REQ-001 Parameter N, default 16: number of parallel lanes.
REQ-002 Parameter WI, default 8: signed input element width.
REQ-003 Parameter CW, default 18: signed GELU constant width; CW > WI.
REQ-004 Parameter OW, default 26: signed output element width; OW >= 2*CW is not required, results wrap to OW.
REQ-005 clk_i  in  1  clock, all state updates on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 mode_i  in  2  activation select: 0 identity, 1 ReLU, 2 i-GELU, 3 identity.
REQ-008 b_i  in  CW  signed GELU constant b (negative in use).
REQ-009 c_i  in  CW  signed GELU constant c.
REQ-010 lane_en_i  in  N  per-lane enable; disabled lane outputs 0.
REQ-011 valid_i  in  1  input beat valid.
REQ-012 ready_o  out  1  block accepts a beat this cycle.
REQ-013 data_i  in  N*WI  N signed lanes, lane k at bits [k*WI +: WI].
REQ-014 flush_i  in  1  synchronous discard of all in-flight beats.
REQ-015 valid_o  out  1  output beat valid.
REQ-016 ready_i  in  1  downstream accepts a beat.
REQ-017 data_o  out  N*OW  N signed results, lane k at bits [k*OW +: OW].

Function
REQ-018 Pipeline SHALL have two register stages (S1, S2); latency valid_i&ready_o to valid_o = 2 cycles with no stall; throughput 1 beat/cycle.
REQ-019 Global enable en = !valid_S2 | ready_i; ready_o SHALL equal en; all stages advance only when en=1.
REQ-020 Handshakes: input beat accepted iff valid_i&ready_o; output beat consumed iff valid_o&ready_i; valid_o and data_o SHALL be stable while valid_o&!ready_i.
REQ-021 mode_i, b_i, c_i, lane_en_i SHALL be captured into S1 with the accepted beat; changes never affect in-flight beats.
REQ-022 Stage-1 GELU per lane: x sign-extended to CW; sgn = x<0; a = |x|; q = min(a, -b); p = q + b; sq = p*p truncated to OW; sq, sgn, x, c registered into S1.
REQ-023 Stage-2 GELU per lane: L = sq + c; e = sgn ? -L : L; s = e + c; y = x * s, all OW-bit two's complement, wrap on overflow; y registered into S2.
REQ-024 Identity: y = x sign-extended to OW; ReLU: y = x<0 ? 0 : x sign-extended.
REQ-025 Disabled lane (captured lane_en bit 0): y = 0 regardless of mode.
REQ-026 x = -2^(WI-1) SHALL use a computed in CW bits (no overflow since CW > WI).
REQ-027 Bubbles: when en=1 and no beat accepted, S1 valid SHALL clear; S2 takes S1 valid.
REQ-028 flush_i=1 SHALL clear S1 and S2 valid bits at the clock edge, override simultaneous acceptance, and leave data registers unchanged; ready_o unaffected by flush_i.
REQ-029 Simultaneous consume at S2 and accept at input in the same cycle SHALL be lossless.
REQ-030 Datapath registers SHALL load only when en=1 (no toggling while stalled).

Reset
REQ-031 On rst_ni=0, all valid bits, S1/S2 data, and captured controls SHALL clear to 0 asynchronously.
REQ-032 Outputs during/after reset: valid_o=0, data_o=0, ready_o=1.
REQ-033 Reset mid-stream SHALL drop all in-flight beats; no output beat appears after release without new input.

Verification
REQ-034 GELU, b=-4, c=10, all lanes on, ready_i=1, lanes x={3,-2,5,-128} -> two cycles later y={63,8,100,0}.
REQ-035 ReLU, x={-7,0,9,-128} -> y={0,0,9,0}; identity x=-7 -> y=-7 sign-extended to OW.
REQ-036 Backpressure: 4 back-to-back beats, ready_i low for 3 cycles after first valid_o -> ready_o low those cycles, valid_o/data_o held, all 4 beats emerge in order, none lost or duplicated.
REQ-037 Change b_i/c_i/mode_i the cycle after a beat is accepted -> that beat's result uses the old values.
REQ-038 flush_i with 2 beats in flight and valid_i high -> valid_o stays 0 for next 2 cycles; lane_en_i=0 on lane 1 -> lane 1 output 0.
REQ-039 Assert rst_ni=0 mid-stream -> valid_o and data_o 0 immediately, ready_o=1 after release.
